// File: rtl/sub_pkg.sv
// Shared definitions for the serial nibble subtractor.
//   NIBBLE_W     width of the borrow-lookahead cell slice
//   MAX_NIBBLES  largest supported operand width in nibbles
//   state_t      sequencer states
//   cnt_width()  nibble counter width, never narrower than one bit
package sub_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int MAX_NIBBLES = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_nibble_sub_if.sv
// Request/result bundle for serial_nibble_sub.
//   master: drives start, X, Y, Bin; observes busy, done, Diff, Bout, Zero
//   slave : the subtractor side of the same signals
interface serial_nibble_sub_if
  import sub_pkg::*;
#(
  parameter int NIBBLES = 4
) ();

  localparam int W = NIBBLES * NIBBLE_W;

  logic         start;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         Zero;

  modport master (
    output start, X, Y, Bin,
    input  busy, done, Diff, Bout, Zero
  );

  modport slave (
    input  start, X, Y, Bin,
    output busy, done, Diff, Bout, Zero
  );

endinterface

// File: rtl/nibble_lookahead_sub.sv
// Combinational 4-bit borrow-lookahead subtractor cell: Diff = X - Y - Bin.
//   X, Y  nibble operands      Bin   borrow in
//   Diff  nibble difference    Bout  borrow out
module nibble_lookahead_sub
  import sub_pkg::*;
(
  output logic [NIBBLE_W-1:0] Diff,
  output logic                Bout,
  input  logic [NIBBLE_W-1:0] X,
  input  logic [NIBBLE_W-1:0] Y,
  input  logic                Bin
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] a;   // borrow passes through a bit where X == Y
  logic [NIBBLE_W:0]   c;

  assign p = X ^ Y;
  assign g = ~X & Y;
  assign a = ~p;

  // Flattened lookahead: every borrow depends only on p/g and Bin.
  assign c[0] = Bin;
  assign c[1] = g[0] | (a[0] & Bin);
  assign c[2] = g[1] | (a[1] & g[0]) | (a[1] & a[0] & Bin);
  assign c[3] = g[2] | (a[2] & g[1]) | (a[2] & a[1] & g[0])
              | (a[2] & a[1] & a[0] & Bin);
  assign c[4] = g[3] | (a[3] & g[2]) | (a[3] & a[2] & g[1])
              | (a[3] & a[2] & a[1] & g[0])
              | (a[3] & a[2] & a[1] & a[0] & Bin);

  assign Diff = p ^ c[NIBBLE_W-1:0];
  assign Bout = c[NIBBLE_W];

endmodule

// File: rtl/serial_nibble_sub.sv
// Multi-cycle unsigned subtractor: Diff = (X - Y - Bin) mod 2^W, one nibble
// per clock through a single borrow-lookahead cell, LSB nibble first.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of serial_nibble_sub_if (start/X/Y/Bin in,
//          busy/done/Diff/Bout/Zero out)
//
// state | meaning
// IDLE  | waiting for start; Diff/Bout/Zero hold the last result
// RUN   | one nibble per cycle through the cell; leaves after the last one
module serial_nibble_sub
  import sub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_nibble_sub_if.slave  bus
);

  localparam int              W     = NIBBLES * NIBBLE_W;
  localparam int              CNT_W = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [W-1:0]        x_sr;
  logic [W-1:0]        y_sr;
  logic [W-1:0]        acc_sr;
  logic [W-1:0]        acc_nxt;
  logic [W-1:0]        diff_q;
  logic                brw;
  logic                bout_q;
  logic                zero_q;
  logic                done_q;
  logic [NIBBLE_W-1:0] cell_d;
  logic                cell_b;
  logic                accept;
  logic                last;

  nibble_lookahead_sub u_cell (
    .Diff (cell_d),
    .Bout (cell_b),
    .X    (x_sr[NIBBLE_W-1:0]),
    .Y    (y_sr[NIBBLE_W-1:0]),
    .Bin  (brw)
  );

  // New nibble enters at the top; after NIBBLES shifts the LSB nibble
  // computed first has arrived at bit 0.
  assign acc_nxt = (acc_sr >> NIBBLE_W) | (W'(cell_d) << (W - NIBBLE_W));

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == RUN) && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      x_sr   <= '0;
      y_sr   <= '0;
      acc_sr <= '0;
      brw    <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        x_sr <= bus.X;
        y_sr <= bus.Y;
        brw  <= bus.Bin;
        cnt  <= '0;
      end else if (state == RUN) begin
        x_sr   <= x_sr >> NIBBLE_W;
        y_sr   <= y_sr >> NIBBLE_W;
        acc_sr <= acc_nxt;
        brw    <= cell_b;
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          diff_q <= acc_nxt;
          bout_q <= cell_b;
          zero_q <= (acc_nxt == '0);
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;
  assign bus.Zero = zero_q;

endmodule

// File: tb/tb_serial_nibble_sub.sv
module tb_serial_nibble_sub;

  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_nibble_sub_if #(.NIBBLES(N)) bus ();

  serial_nibble_sub #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_d, held_d;
  logic         exp_b, held_b, exp_z, held_z;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Reference: plain signed arithmetic on the full words.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
    longint v;
    v = longint'(x) - longint'(y) - longint'(b);
    exp_b = (v < 0);
    if (v < 0) v = v + (longint'(1) << W);
    exp_d = W'(v);
    exp_z = (exp_d == '0);
  endtask

  // Called just after a negedge; returns just after the accept edge with
  // the inputs scrambled so in-flight results must not depend on them.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
    model(x, y, b);
    bus.start = 1'b1;
    bus.X     = x;
    bus.Y     = y;
    bus.Bin   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.X     = W'($urandom);
    bus.Y     = W'($urandom);
    bus.Bin   = 1'($urandom);
  endtask

  // k = index of the edge after acceptance (0 = sample after E0).
  // Returns at the negedge where done is seen.
  task automatic finish_op(input int inject_at);
    int  k;
    int  busy_cnt;
    bit  seen;
    k = -1;
    busy_cnt = 0;
    seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        seen = 1;
      end else begin
        if (bus.busy === 1'b1) busy_cnt++;
        check("hold_diff", 32'(bus.Diff), 32'(held_d));
        check("hold_bout", 32'(bus.Bout), 32'(held_b));
        if (k == inject_at) begin
          bus.start = 1'b1;
          bus.X     = '1;
          bus.Y     = '0;
        end
      end
    end
    check("latency", 32'(k), 32'(N));
    check("busy_cycles", 32'(busy_cnt), 32'(N));
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("diff", 32'(bus.Diff), 32'(exp_d));
    check("bout", 32'(bus.Bout), 32'(exp_b));
    check("zero", 32'(bus.Zero), 32'(exp_z));
    held_d = exp_d;
    held_b = exp_b;
    held_z = exp_z;
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
    @(negedge clk);
    launch(x, y, b);
    finish_op(-1);
    @(negedge clk);
    check("done_width", 32'(bus.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int extra;
    logic [W-1:0] rx, ry;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.X     = '0;
    bus.Y     = '0;
    bus.Bin   = 1'b0;
    held_d = '0; held_b = 1'b0; held_z = 1'b0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.Diff), 32'd0);
    check("rst_bout", 32'(bus.Bout), 32'd0);
    check("rst_zero", 32'(bus.Zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    op(16'h1234, 16'h0235, 1'b0);
    check("vec1_diff", 32'(held_d), 32'h0FFF);
    op(16'h0000, 16'h0001, 1'b0);
    check("vec2_bout", 32'(bus.Bout), 32'd1);
    op(16'h8000, 16'h7FFF, 1'b1);
    check("vec3_zero", 32'(bus.Zero), 32'd1);

    // start while busy is ignored; inputs also change mid-operation
    @(negedge clk);
    launch(16'hA5C3, 16'h3C5A, 1'b1);
    finish_op(1);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    check("ignored_start_done", 32'(extra), 32'd0);
    check("ignored_start_busy", 32'(bus.busy), 32'd0);

    // Back-to-back: accept during the done cycle
    @(negedge clk);
    launch(16'h1000, 16'h0001, 1'b0);
    finish_op(-1);
    launch(16'h0F0F, 16'hF0F0, 1'b1);
    check("b2b_done_drop", 32'(bus.done), 32'd0);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check("b2b_hold", 32'(bus.Diff), 32'h0FFF);
    finish_op(-1);

    // Reset in the middle of RUN
    @(negedge clk);
    launch(16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_done", 32'(bus.done), 32'd0);
    check("mrst_diff", 32'(bus.Diff), 32'd0);
    check("mrst_bout", 32'(bus.Bout), 32'd0);
    check("mrst_zero", 32'(bus.Zero), 32'd0);
    held_d = '0; held_b = 1'b0; held_z = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    check("mrst_no_done", 32'(extra), 32'd0);
    op(16'h0005, 16'h0003, 1'b0);
    check("mrst_after", 32'(held_d), 32'h0002);

    // Randomized operations, some back-to-back
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      if (i % 5 == 0) ry = rx;
      if (i % 7 == 3) begin rx = '0; ry = '1; end
      launch(rx, ry, 1'($urandom));
      finish_op(-1);
      if ($urandom_range(0, 2) != 0) begin
        @(negedge clk);
        check("rnd_done_width", 32'(bus.done), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
